// File: rtl/system_pio_edge_in.sv
// Avalon-MM input PIO: per-bit synchroniser, optional debounce, rise/fall edge capture with W1C flags and masked irq.
// Optional debounce filter enabled by defining SYSTEM_PIO_EDGE_IN_DEBOUNCE_EN.
module system_pio_edge_in #(
    parameter int WIDTH    = 8,
    parameter int DB_CW    = 16,
    parameter int DB_RESET = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;

    // Detection stays off until the synchroniser holds post-reset data,
    // so an input already high at reset release never looks like an edge.
    localparam logic [1:0] WARM_DONE = 2'd3;

    logic             wr_en;
    logic [WIDTH-1:0] wr_bits;

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] rise_en_reg;
    logic [WIDTH-1:0] fall_en_reg;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] edge_cap_reg;
    logic [WIDTH-1:0] edge_cap_next;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;
    logic [1:0]       warm_cnt_reg;
    logic             warm_done;
    logic [31:0]      debounce_ext;
    logic [31:0]      rd_mux;
    logic [31:0]      readdata_reg;

    assign wr_en   = chipselect & ~write_n;
    assign wr_bits = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_wdata_pad
            logic unused_wdata;
            assign unused_wdata = &{1'b0, writedata[31:WIDTH]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt_reg <= '0;
        end else if (warm_cnt_reg != WARM_DONE) begin
            warm_cnt_reg <= warm_cnt_reg + 2'd1;
        end
    end

    assign warm_done = (warm_cnt_reg == WARM_DONE);

`ifdef SYSTEM_PIO_EDGE_IN_DEBOUNCE_EN
    logic [DB_CW-1:0] debounce_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            debounce_reg <= DB_CW'(DB_RESET);
        end else if (wr_en && address == ADDR_DEBOUNCE) begin
            debounce_reg <= writedata[DB_CW-1:0];
        end
    end

    always_comb begin
        debounce_ext = '0;
        debounce_ext[DB_CW-1:0] = debounce_reg;
    end

    // filt only follows sync2 once it has differed for more than DEBOUNCE clocks
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_db
            logic [DB_CW-1:0] cnt_reg;
            logic             filt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg  <= '0;
                    filt_reg <= 1'b0;
                end else if (sync2_reg[gi] == filt_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg >= debounce_reg) begin
                    filt_reg <= sync2_reg[gi];
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + DB_CW'(1);
                end
            end

            assign filt[gi] = filt_reg;
        end
    endgenerate
`else
    logic [DB_CW-1:0] unused_db;
    assign unused_db    = DB_CW'(DB_RESET);
    assign filt         = sync2_reg;
    assign debounce_ext = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= filt;
        end
    end

    genvar gj;
    generate
        for (gj = 0; gj < WIDTH; gj++) begin : g_edge
            assign det[gj] = warm_done &
                             ((filt[gj] & ~prev_reg[gj] & rise_en_reg[gj]) |
                              (~filt[gj] & prev_reg[gj] & fall_en_reg[gj]));
            assign clr[gj] = wr_en && (address == ADDR_EDGE_CAP) && wr_bits[gj];
            // Set wins over clear so an edge coinciding with a W1C is kept
            assign edge_cap_next[gj] = (edge_cap_reg[gj] & ~clr[gj]) | det[gj];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en_reg  <= '1;
            fall_en_reg  <= '0;
            irq_mask_reg <= '0;
            edge_cap_reg <= '0;
        end else begin
            edge_cap_reg <= edge_cap_next;
            if (wr_en) begin
                case (address)
                    ADDR_RISE_EN:  rise_en_reg  <= wr_bits;
                    ADDR_IRQ_MASK: irq_mask_reg <= wr_bits;
                    ADDR_FALL_EN:  fall_en_reg  <= wr_bits;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:     rd_mux[WIDTH-1:0] = filt;
            ADDR_RISE_EN:  rd_mux[WIDTH-1:0] = rise_en_reg;
            ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask_reg;
            ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap_reg;
            ADDR_FALL_EN:  rd_mux[WIDTH-1:0] = fall_en_reg;
            ADDR_DEBOUNCE: rd_mux = debounce_ext;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_reg <= '0;
        end else begin
            readdata_reg <= rd_mux;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = |(edge_cap_reg & irq_mask_reg);

endmodule

// File: tb/tb_system_pio_edge_in.sv
// Self-checking bench for system_pio_edge_in: register table plus edge-capture timing sequences.
module tb_system_pio_edge_in;

`ifdef SYSTEM_PIO_EDGE_IN_DEBOUNCE_EN
    localparam int          XL     = 1;
    localparam logic [31:0] DB_DEF = 32'd1000;
`else
    localparam int          XL     = 0;
    localparam logic [31:0] DB_DEF = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vec[$];

    system_pio_edge_in #(.WIDTH(8), .DB_CW(16), .DB_RESET(1000)) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("wr addr=%0d data=%h", a, d);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        logic [31:0] ex;
        string       nm;
        address = a;
        exp_q.push_back(e);
        name_q.push_back(n);
        tick();
        ex = exp_q.pop_front();
        nm = name_q.pop_front();
        $display("rd addr=%0d data=%h", a, readdata);
        check(nm, readdata, ex);
    endtask

    task automatic chk_irq(input logic e, input string n);
        $display("irq %s = %0b", n, irq);
        check(n, {31'd0, irq}, {31'd0, e});
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        repeat (3) tick();
        check("reset_readdata", readdata, 32'h0);
        chk_irq(1'b0, "reset_irq");
        reset = 1'b0;
        repeat (4) tick();

        // Register map table: reset values, RW readback, ignored bits/addresses
        vec.push_back('{0, 3'd0, 32'h0, 32'h0});
        vec.push_back('{0, 3'd1, 32'h0, 32'hFF});
        vec.push_back('{0, 3'd2, 32'h0, 32'h0});
        vec.push_back('{0, 3'd3, 32'h0, 32'h0});
        vec.push_back('{0, 3'd4, 32'h0, 32'h0});
        vec.push_back('{0, 3'd5, 32'h0, DB_DEF});
        vec.push_back('{0, 3'd6, 32'h0, 32'h0});
        vec.push_back('{0, 3'd7, 32'h0, 32'h0});
        vec.push_back('{1, 3'd1, 32'h000000A5, 32'h0});
        vec.push_back('{0, 3'd1, 32'h0, 32'hA5});
        vec.push_back('{1, 3'd4, 32'hFFFFFF3C, 32'h0});
        vec.push_back('{0, 3'd4, 32'h0, 32'h3C});
        vec.push_back('{1, 3'd2, 32'h12345681, 32'h0});
        vec.push_back('{0, 3'd2, 32'h0, 32'h81});
        vec.push_back('{1, 3'd6, 32'hFFFFFFFF, 32'h0});
        vec.push_back('{0, 3'd6, 32'h0, 32'h0});
        vec.push_back('{1, 3'd0, 32'h000000FF, 32'h0});
        vec.push_back('{0, 3'd0, 32'h0, 32'h0});
        vec.push_back('{1, 3'd5, 32'h00001234, 32'h0});
        vec.push_back('{0, 3'd5, 32'h0, (XL != 0) ? 32'h1234 : 32'h0});
        vec.push_back('{1, 3'd3, 32'h000000FF, 32'h0});
        vec.push_back('{0, 3'd3, 32'h0, 32'h0});
        for (int i = 0; i < vec.size(); i++) begin
            if (vec[i].wr) wr(vec[i].addr, vec[i].wdata);
            else rd(vec[i].addr, vec[i].exp, $sformatf("vec%0d", i));
        end

        if (XL != 0) wr(3'd5, 32'h0);
        wr(3'd1, 32'hFF);
        wr(3'd4, 32'h0);
        wr(3'd2, 32'h08);

        // Rising edge on bit 3: flag and irq appear at E2
        in_port = 8'h08;
        repeat (2 + XL) tick();
        chk_irq(1'b0, "rise3_irq_early");
        tick();
        chk_irq(1'b1, "rise3_irq_e2");
        rd(3'd3, 32'h08, "rise3_cap");
        rd(3'd0, 32'h08, "rise3_data");
        wr(3'd3, 32'h08);
        chk_irq(1'b0, "rise3_irq_cleared");
        rd(3'd3, 32'h0, "rise3_cap_cleared");
        in_port = 8'h00;
        repeat (6) tick();
        rd(3'd3, 32'h0, "fall3_not_enabled");

        // Falling-only capture on bit 0
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h01);
        wr(3'd2, 32'h01);
        in_port = 8'h01;
        repeat (10) tick();
        chk_irq(1'b0, "pulse0_no_rise");
        in_port = 8'h00;
        repeat (2 + XL) tick();
        chk_irq(1'b0, "pulse0_fall_early");
        tick();
        chk_irq(1'b1, "pulse0_fall_irq");
        rd(3'd3, 32'h01, "pulse0_cap");
        wr(3'd3, 32'h01);
        chk_irq(1'b0, "pulse0_cleared");

        // W1C in the same cycle the bit-2 edge is detected: set wins
        wr(3'd1, 32'h04);
        wr(3'd4, 32'h0);
        wr(3'd2, 32'h0);
        in_port = 8'h04;
        repeat (2 + XL) tick();
        wr(3'd3, 32'h04);
        rd(3'd3, 32'h04, "w1c_race_kept");
        wr(3'd3, 32'hFB);
        rd(3'd3, 32'h04, "w1c_zero_noop");
        chk_irq(1'b0, "masked_irq");
        wr(3'd1, 32'h0);
        rd(3'd3, 32'h04, "rise_en_change_keeps");
        wr(3'd2, 32'h04);
        chk_irq(1'b1, "mask_set_irq");

`ifdef SYSTEM_PIO_EDGE_IN_DEBOUNCE_EN
        // Debounce of 4: a 4-cycle glitch is rejected, a 6-cycle hold passes
        wr(3'd1, 32'h02);
        wr(3'd4, 32'h0);
        wr(3'd2, 32'h02);
        wr(3'd3, 32'hFF);
        in_port = 8'h00;
        repeat (6) tick();
        wr(3'd5, 32'd4);
        in_port = 8'h02;
        repeat (4) tick();
        in_port = 8'h00;
        repeat (8) tick();
        chk_irq(1'b0, "db_glitch_irq");
        rd(3'd0, 32'h0, "db_glitch_data");
        rd(3'd3, 32'h0, "db_glitch_cap");
        in_port = 8'h02;
        repeat (6) tick();
        chk_irq(1'b0, "db_hold_irq_e5");
        rd(3'd0, 32'h0, "db_hold_data_pre_e6");
        chk_irq(1'b0, "db_hold_irq_e6");
        rd(3'd0, 32'h02, "db_hold_data_e6");
        chk_irq(1'b1, "db_hold_irq_e7");
        wr(3'd5, 32'hFFFF0003);
        rd(3'd5, 32'h3, "db_upper_ignored");
`endif

        // Reset mid-operation, with all inputs high across release
        in_port = 8'hFF;
        reset   = 1'b1;
        tick();
        chk_irq(1'b0, "midreset_irq");
        check("midreset_readdata", readdata, 32'h0);
        tick();
        reset = 1'b0;
        wr(3'd2, 32'hFF);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_irq(1'b0, $sformatf("held_high_irq%0d", i));
        end
        rd(3'd3, 32'h0, "held_high_cap");
        rd(3'd0, (XL != 0) ? 32'h0 : 32'hFF, "held_high_data");
        rd(3'd1, 32'hFF, "reset_rise_en");
        rd(3'd4, 32'h0, "reset_fall_en");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
